coin_in_ctrl: RTL
=================

Name: coin_in_ctrl

Overview:
Coin-acceptor front end for the cola vending FSM.
- Conditions two raw active-low coin switches: a 0.5-unit coin switch and a 1.0-unit coin switch.
- Synchronises and debounces each switch, then emits exactly one single-cycle coin event per physical insertion.
- Output encoding matches the vending FSM money input: po_money = 0 means 0.5, po_money = 1 means 1.0.
- The vending FSM consumes the event only when po_money_vld is high.

Parameters:
- CNT_MAX, 999_999, debounce hold count in clk cycles (20 ms at 50 MHz). Must be ≥ 2. Benches use 9.
- CNT_W, 20, debounce counter width. Must satisfy 2^CNT_W > CNT_MAX.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset: asynchronous, active-low.
- key_half_n  input  1  raw 0.5-coin switch, asynchronous, low = pressed.
- key_one_n  input  1  raw 1.0-coin switch, asynchronous, low = pressed.
- po_money_vld  output  1  one-cycle coin event strobe.
- po_money  output  1  coin value, qualified by po_money_vld: 0 = 0.5, 1 = 1.0.
- po_coin_total  output  8  running total in 0.5 units. Present only with COIN_TOTAL_EN.

Behaviour:
- Reset values:
  - po_money_vld = 0, po_money = 0, po_coin_total = 0.
  - Sync flops = 1 (released).
  - Both key FSMs in IDLE, counters = 0, half_pend = 0.
- Synchronisers: each raw key passes through a 2-FF synchroniser. The debounce FSM sees only the 2nd flop (k_s).
- Per-key FSM (one-hot, 4 states), identical for both keys. cnt counts while in PRESS_WAIT and REL_WAIT; it is cleared on every state change.
  - IDLE: k_s = 0 → PRESS_WAIT, cnt = 0.
  - PRESS_WAIT:
    - k_s = 1 → IDLE (bounce rejected).
    - else if cnt == CNT_MAX → PRESSED and raise an internal event for one cycle.
    - else cnt + 1.
  - PRESSED: k_s = 1 → REL_WAIT, cnt = 0. Holding the key never re-fires.
  - REL_WAIT:
    - k_s = 0 → PRESSED (release bounce, no new event).
    - else if cnt == CNT_MAX → IDLE.
    - else cnt + 1.
- Latency: for a key held low continuously, po_money_vld rises at rising edge CNT_MAX+4, counting the first edge that samples the key low as edge 1. po_money_vld is high for exactly 1 cycle.
- Output arbitration (registered, evaluated each cycle):
  - one_evt only → vld = 1, money = 1.
  - half_evt only, or half_pend = 1 → vld = 1, money = 0. Clear half_pend.
  - one_evt and half_evt in the same cycle → emit 1.0 now and set half_pend. The 0.5 event is emitted on the next cycle. No coin is lost; 1.0 always has priority.
  - No event → vld = 0, money = 0. money is driven 0 whenever vld = 0.
- Back-to-back events: debounce makes a new event impossible within CNT_MAX cycles, so half_pend never overflows.
- Reset mid-operation: any partially debounced press is discarded. A key still held after reset release is re-debounced from IDLE and produces one event CNT_MAX+4 edges after reset deassertion.

Optional Feature:
- Macro: COIN_TOTAL_EN.
- Defined:
  - po_coin_total is an 8-bit register of accumulated value in 0.5 units.
  - Adds 1 for each 0.5 event and 2 for each 1.0 event, updated on the same edge po_money_vld is driven high.
  - Saturates at 255: no wrap, and a +2 at 254 gives 255.
  - Cleared only by rst_n.
- Undefined: the port and register are absent. All other behaviour is identical.

Test Plan:
- Clean press, CNT_MAX=9: key_one_n low for 30 cycles, then high → one vld pulse at edge 13 with money = 1. No further pulse while held or after release.
- Bounce rejection: key_half_n toggles low 5 cycles / high 3 cycles, 4 times, then held low → exactly one vld with money = 0, 13 edges after the final low edge. Zero pulses during bouncing.
- Release bounce: after a debounced half press, key_half_n glitches high for 4 cycles then low again, then releases cleanly → no second event.
- Simultaneous: both keys go low on the same cycle → vld at edge 13 with money = 1, then vld at edge 14 with money = 0. vld = 0 afterwards.
- Reset mid-debounce: key_one_n low, rst_n asserted at edge 8 for 3 cycles, key still held → no event before reset. One event 13 edges after rst_n deassertion. Outputs are 0 during reset.
- COIN_TOTAL_EN: 127 one-coins then a half-coin → total reads 254, then 255. Another one-coin → stays 255.

Source files
------------

// File: rtl/coin_in_ctrl.sv
// Coin-acceptor front end: synchronises and debounces the two coin switches and emits one money event per insertion.
// Optional macro COIN_TOTAL_EN adds a saturating running total (po_coin_total) in 0.5 units.
module coin_in_ctrl #(
  parameter int CNT_MAX = 999_999,
  parameter int CNT_W   = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_half_n,
  input  logic       key_one_n,
  output logic       po_money_vld,
  output logic       po_money
`ifdef COIN_TOTAL_EN
  ,
  output logic [7:0] po_coin_total
`endif
);

  typedef enum logic [3:0] {
    IDLE       = 4'b0001,
    PRESS_WAIT = 4'b0010,
    PRESSED    = 4'b0100,
    REL_WAIT   = 4'b1000
  } key_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

  logic [1:0] key_raw;
  logic [1:0] evt;
  logic       half_pend;

  assign key_raw = {key_one_n, key_half_n};

  // Index 0 is the 0.5 switch, index 1 the 1.0 switch.
  for (genvar g = 0; g < 2; g++) begin : g_key
    logic             sync1;
    logic             k_s;
    key_state_t       state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1 <= 1'b1;
        k_s   <= 1'b1;
      end else begin
        sync1 <= key_raw[g];
        k_s   <= sync1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!k_s) begin
              state <= PRESS_WAIT;
              cnt   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (k_s) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state <= PRESSED;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          PRESSED: begin
            if (k_s) begin
              state <= REL_WAIT;
              cnt   <= '0;
            end
          end
          REL_WAIT: begin
            if (!k_s) begin
              state <= PRESSED;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    // Decoded from the PRESS_WAIT->PRESSED transition so the output register catches it on the same edge.
    assign evt[g] = (state == PRESS_WAIT) && !k_s && (cnt == CNT_LAST);
  end

  // A simultaneous 0.5 coin is parked in half_pend and emitted the cycle after the 1.0 coin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      po_money_vld <= 1'b0;
      po_money     <= 1'b0;
      half_pend    <= 1'b0;
    end else if (evt[1]) begin
      po_money_vld <= 1'b1;
      po_money     <= 1'b1;
      if (evt[0]) half_pend <= 1'b1;
    end else if (evt[0] || half_pend) begin
      po_money_vld <= 1'b1;
      po_money     <= 1'b0;
      half_pend    <= 1'b0;
    end else begin
      po_money_vld <= 1'b0;
      po_money     <= 1'b0;
    end
  end

`ifdef COIN_TOTAL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      po_coin_total <= 8'd0;
    end else if (evt[1]) begin
      po_coin_total <= (po_coin_total >= 8'd253) ? 8'd255 : po_coin_total + 8'd2;
    end else if (evt[0] || half_pend) begin
      po_coin_total <= (po_coin_total == 8'd255) ? 8'd255 : po_coin_total + 8'd1;
    end
  end
`endif

endmodule
